// File: rtl/prco_decoder_pipe.sv
// ============================================================================
// Module  : prco_decoder_pipe
// Purpose : Pipelined instruction decoder with a 2-entry (output + skid) buffer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prco_decoder_pipe #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int IMM_W   = 8,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              q_ready,
  input  logic [INSTR_W-1:0] i_instr,
  output logic              q_valid,
  input  logic              i_ready,
  output logic [OP_W-1:0]   q_op,
  output logic [SEL_W-1:0]  q_seld,
  output logic [SEL_W-1:0]  q_sela,
  output logic [SEL_W-1:0]  q_selb,
  output logic [DATA_W-1:0] q_imm,
  output logic [DATA_W-1:0] q_imm_sx,
  output logic              q_reg_we,
  output logic              q_mem_we,
  output logic              q_branch,
  output logic              q_illegal,
  output logic [CNT_W-1:0]  q_count
);

  localparam logic [OP_W-1:0] C_OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] C_OP_MOV  = OP_W'(1);
  localparam logic [OP_W-1:0] C_OP_MOVI = OP_W'(2);
  localparam logic [OP_W-1:0] C_OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] C_OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] C_OP_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] C_OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] C_OP_XOR  = OP_W'(7);
  localparam logic [OP_W-1:0] C_OP_NOT  = OP_W'(8);
  localparam logic [OP_W-1:0] C_OP_SHL  = OP_W'(9);
  localparam logic [OP_W-1:0] C_OP_SHR  = OP_W'(10);
  localparam logic [OP_W-1:0] C_OP_CMP  = OP_W'(11);
  localparam logic [OP_W-1:0] C_OP_SW   = OP_W'(12);
  localparam logic [OP_W-1:0] C_OP_JMP  = OP_W'(13);
  localparam logic [OP_W-1:0] C_OP_JMPC = OP_W'(14);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] seld;
    logic [SEL_W-1:0] sela;
    logic [SEL_W-1:0] selb;
    logic [IMM_W-1:0] imm;
    logic             reg_we;
    logic             mem_we;
    logic             branch;
    logic             illegal;
  } entry_t;

  entry_t           dec_d;
  entry_t           out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, deliver, flush;

  always_comb begin
    dec_d         = '0;
    dec_d.op      = i_instr[INSTR_W-1 -: OP_W];
    dec_d.seld    = i_instr[INSTR_W-OP_W-1 -: SEL_W];
    dec_d.sela    = i_instr[INSTR_W-OP_W-SEL_W-1 -: SEL_W];
    dec_d.selb    = i_instr[INSTR_W-OP_W-2*SEL_W-1 -: SEL_W];
    dec_d.imm     = i_instr[IMM_W-1:0];
    case (dec_d.op)
      C_OP_NOP, C_OP_CMP: ;
      C_OP_MOV, C_OP_MOVI, C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR,
      C_OP_XOR, C_OP_NOT, C_OP_SHL, C_OP_SHR: dec_d.reg_we = 1'b1;
      C_OP_SW:             dec_d.mem_we  = 1'b1;
      C_OP_JMP, C_OP_JMPC: dec_d.branch  = 1'b1;
      default:             dec_d.illegal = 1'b1;
    endcase
  end

  // q_ready is ~skid_valid_q, so an accept can never coincide with a full skid.
  assign accept  = i_en & i_valid & q_ready & ~i_flush;
  assign deliver = i_en & out_valid_q & i_ready;
  assign flush   = i_en & i_flush;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    count_d      = deliver ? count_q + CNT_W'(1) : count_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deliver) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_d;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_d;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    q_imm_sx              = {DATA_W{out_q.imm[IMM_W-1]}};
    q_imm_sx[IMM_W-1:0]   = out_q.imm;
  end

  assign q_ready   = ~skid_valid_q;
  assign q_valid   = out_valid_q;
  assign q_op      = out_q.op;
  assign q_seld    = out_q.seld;
  assign q_sela    = out_q.sela;
  assign q_selb    = out_q.selb;
  assign q_imm     = DATA_W'(out_q.imm);
  assign q_reg_we  = out_valid_q & out_q.reg_we;
  assign q_mem_we  = out_valid_q & out_q.mem_we;
  assign q_branch  = out_valid_q & out_q.branch;
  assign q_illegal = out_valid_q & out_q.illegal;
  assign q_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_prco_decoder_pipe.sv
// ============================================================================
// Module  : tb_prco_decoder_pipe
// Purpose : Directed vector bench for prco_decoder_pipe (counter width 4)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prco_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset, en, flush, valid, ready;
  logic [15:0] instr;
  logic        q_ready, q_valid, q_reg_we, q_mem_we, q_branch, q_illegal;
  logic [4:0]  q_op;
  logic [2:0]  q_seld, q_sela, q_selb;
  logic [15:0] q_imm, q_imm_sx;
  logic [3:0]  q_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prco_decoder_pipe #(.CNT_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_flush(flush),
    .i_valid(valid), .q_ready(q_ready), .i_instr(instr),
    .q_valid(q_valid), .i_ready(ready), .q_op(q_op),
    .q_seld(q_seld), .q_sela(q_sela), .q_selb(q_selb),
    .q_imm(q_imm), .q_imm_sx(q_imm_sx), .q_reg_we(q_reg_we),
    .q_mem_we(q_mem_we), .q_branch(q_branch), .q_illegal(q_illegal),
    .q_count(q_count)
  );

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  op;
    logic [2:0]  seld, sela, selb;
    logic [15:0] imm, imm_sx;
    logic [3:0]  flags; // {reg_we, mem_we, branch, illegal}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] cnt);
    check({tag, " valid"}, 32'(q_valid), 32'd0);
    check({tag, " ready"}, 32'(q_ready), 32'd1);
    check({tag, " flags"}, 32'({q_reg_we, q_mem_we, q_branch, q_illegal}), 32'd0);
    check({tag, " count"}, 32'(q_count), 32'(cnt));
  endtask

  initial begin
    vecs[0]  = '{16'h10AB, 5'd2,  3'd0, 3'd5, 3'd2, 16'h00AB, 16'hFFAB, 4'b1000};
    vecs[1]  = '{16'h0000, 5'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 4'b0000};
    vecs[2]  = '{16'h11CD, 5'd2,  3'd1, 3'd6, 3'd3, 16'h00CD, 16'hFFCD, 4'b1000};
    vecs[3]  = '{16'h0940, 5'd1,  3'd1, 3'd2, 3'd0, 16'h0040, 16'h0040, 4'b1000};
    vecs[4]  = '{16'h6394, 5'd12, 3'd3, 3'd4, 3'd5, 16'h0094, 16'hFF94, 4'b0100};
    vecs[5]  = '{16'h687F, 5'd13, 3'd0, 3'd3, 3'd7, 16'h007F, 16'h007F, 4'b0010};
    vecs[6]  = '{16'h7280, 5'd14, 3'd2, 3'd4, 3'd0, 16'h0080, 16'hFF80, 4'b0010};
    vecs[7]  = '{16'h5828, 5'd11, 3'd0, 3'd1, 3'd2, 16'h0028, 16'h0028, 4'b0000};
    vecs[8]  = '{16'h1FFF, 5'd3,  3'd7, 3'd7, 3'd7, 16'h00FF, 16'hFFFF, 4'b1000};
    vecs[9]  = '{16'hF801, 5'd31, 3'd0, 3'd0, 3'd0, 16'h0001, 16'h0001, 4'b0001};
    vecs[10] = '{16'h8555, 5'd16, 3'd5, 3'd2, 3'd5, 16'h0055, 16'h0055, 4'b0001};
    vecs[11] = '{16'h5600, 5'd10, 3'd6, 3'd0, 3'd0, 16'h0000, 16'h0000, 4'b1000};

    reset = 1'b1; en = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; instr = '0;
    step(); step();
    reset = 1'b0;
    step();
    check_idle("reset", 4'd0);
    check("reset op", 32'(q_op), 32'd0);
    check("reset imm_sx", 32'(q_imm_sx), 32'd0);

    // Back-to-back stream: vector i is on the output and i earlier ones delivered.
    for (int i = 0; i < 12; i++) begin
      instr = vecs[i].instr; valid = 1'b1;
      step();
      check($sformatf("v%0d valid", i), 32'(q_valid), 32'd1);
      check($sformatf("v%0d op", i), 32'(q_op), 32'(vecs[i].op));
      check($sformatf("v%0d sel", i), 32'({q_seld, q_sela, q_selb}),
            32'({vecs[i].seld, vecs[i].sela, vecs[i].selb}));
      check($sformatf("v%0d imm", i), 32'(q_imm), 32'(vecs[i].imm));
      check($sformatf("v%0d imm_sx", i), 32'(q_imm_sx), 32'(vecs[i].imm_sx));
      check($sformatf("v%0d flags", i), 32'({q_reg_we, q_mem_we, q_branch, q_illegal}),
            32'(vecs[i].flags));
      check($sformatf("v%0d count", i), 32'(q_count), 32'(i));
    end
    valid = 1'b0;
    step();
    check_idle("drain", 4'd12);
    check("hold op", 32'(q_op), 32'd10);

    // Stall: offer three words, only two fit.
    ready = 1'b0; valid = 1'b1; instr = vecs[0].instr;
    step();
    check("stall0 ready", 32'(q_ready), 32'd1);
    instr = vecs[4].instr;
    step();
    check("stall1 ready", 32'(q_ready), 32'd0);
    check("stall1 op", 32'(q_op), 32'd2);
    instr = vecs[5].instr;
    step();
    check("stall2 ready", 32'(q_ready), 32'd0);
    check("stall2 op", 32'(q_op), 32'd2);
    valid = 1'b0; ready = 1'b1;
    step();
    check("unstall op", 32'(q_op), 32'd12);
    check("unstall memwe", 32'(q_mem_we), 32'd1);
    check("unstall ready", 32'(q_ready), 32'd1);
    check("unstall count", 32'(q_count), 32'd13);
    step();
    check_idle("unstall end", 4'd14);

    // Flush with both entries full and a concurrent offer, no deliver.
    ready = 1'b0; valid = 1'b1; instr = vecs[2].instr;
    step();
    instr = vecs[3].instr;
    step();
    check("pre-flush ready", 32'(q_ready), 32'd0);
    flush = 1'b1; instr = vecs[8].instr;
    step();
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    check_idle("flush", 4'd14);
    step();
    check_idle("flush after", 4'd14);

    // Flush with a concurrent deliver: the deliver still counts.
    ready = 1'b0; valid = 1'b1; instr = vecs[2].instr;
    step();
    instr = vecs[3].instr;
    step();
    ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; valid = 1'b0;
    check_idle("flush+deliver", 4'd15);

    // Counter wrap 15 -> 0 -> 1.
    valid = 1'b1; instr = vecs[0].instr;
    step();
    check("wrap a", 32'(q_count), 32'd15);
    instr = vecs[3].instr;
    step();
    check("wrap b", 32'(q_count), 32'd0);
    check("wrap b op", 32'(q_op), 32'd1);
    valid = 1'b0;
    step();
    check("wrap c", 32'(q_count), 32'd1);

    // Enable low: held word stays, nothing accepted or delivered.
    ready = 1'b0; valid = 1'b1; instr = vecs[5].instr;
    step();
    en = 1'b0; ready = 1'b1; instr = vecs[4].instr;
    step();
    check("en0 valid", 32'(q_valid), 32'd1);
    check("en0 op", 32'(q_op), 32'd13);
    check("en0 count", 32'(q_count), 32'd1);
    check("en0 ready", 32'(q_ready), 32'd1);
    en = 1'b1;
    step();
    check("en1 op", 32'(q_op), 32'd12);
    check("en1 count", 32'(q_count), 32'd2);

    // Reset with a word buffered.
    ready = 1'b0; instr = vecs[8].instr;
    step();
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; valid = 1'b0;
    check_idle("mid reset", 4'd0);
    check("mid reset fields", 32'({q_op, q_seld, q_sela, q_selb}), 32'd0);
    check("mid reset imm", 32'({q_imm, q_imm_sx}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
